// File: rtl/exec_pkg.sv
// Shared encodings and types for the registered RV32I execute stage.
package exec_pkg;

  // Major opcodes handled by the stage
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  // funct3 encodings
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 encodings
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Stage control state
  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  // Decoded single-cycle ALU operation
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier returning the low XLEN bits of a*b.
// Retires MUL_BITS multiplier bits on every cycle that step is high.
module seq_multiplier #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic            clear,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int unsigned K    = XLEN / MUL_BITS;
  localparam int unsigned CntW = $clog2(K + 1);

  logic            r_active;
  logic [CntW-1:0] r_cnt;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;

  logic [XLEN-1:0] w_pp;
  logic [XLEN-1:0] w_acc_next;
  logic            w_last;

  // Partial product of the shifted multiplicand and the low MUL_BITS multiplier bits
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < int'(MUL_BITS); i++) begin
      if (r_mplier[i]) begin
        w_pp = w_pp + (r_mcand << i);
      end
    end
    w_acc_next = r_acc + w_pp;
    w_last     = (r_cnt == CntW'(K - 1));
    done       = r_active & step & w_last;
    product    = w_acc_next;
  end

  // Operand capture and one retirement step per enabled cycle; clear abandons the product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (clear) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
    end else if (step && r_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
      r_cnt    <= r_cnt + CntW'(1);
      if (w_last) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_unit_pipe.sv
// Registered RV32I execute stage: single-cycle ALU, optional iterative MUL,
// one-entry output buffer behind a valid/ready handshake.
module exec_unit_pipe
  import exec_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ENABLE_MUL = 1,
  parameter int unsigned MUL_BITS   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  output logic            busy
);

  localparam int unsigned ShW  = $clog2(XLEN);
  localparam int unsigned ImmW = (XLEN < 12) ? XLEN : 12;

  state_e          r_state;
  logic            r_out_valid;
  logic [XLEN-1:0] r_out_result;
  logic [4:0]      r_out_rd;
  logic            r_out_illegal;
  logic [4:0]      r_mul_rd;

  logic            w_accept;
  logic            w_is_mul;
  logic            w_illegal;
  logic            w_use_imm;
  alu_op_e         w_alu_op;
  logic [11:0]     w_imm12;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [ShW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_result;
  logic            w_mul_start;
  logic            w_mul_done;
  logic [XLEN-1:0] w_mul_product;

  // Handshake: accept only when idle, powered, not flushing and the buffer can take a result
  always_comb begin
    in_ready = enable & ~rst & ~flush & (r_state == IDLE) & (~r_out_valid | out_ready);
    w_accept = in_valid & in_ready;
    w_imm12  = 12'(imm[ImmW-1:0]);
  end

  // Instruction decode into ALU op, immediate select, MUL and illegal flags
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_illegal = 1'b1;
    w_is_mul  = 1'b0;
    w_use_imm = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE) begin
          w_illegal = 1'b0;
          case (funct3)
            F3_ADD_SUB: w_alu_op = ALU_ADD;
            F3_SLL:     w_alu_op = ALU_SLL;
            F3_SLT:     w_alu_op = ALU_SLT;
            F3_SLTU:    w_alu_op = ALU_SLTU;
            F3_XOR:     w_alu_op = ALU_XOR;
            F3_SR:      w_alu_op = ALU_SRL;
            F3_OR:      w_alu_op = ALU_OR;
            default:    w_alu_op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD_SUB) begin
            w_alu_op  = ALU_SUB;
            w_illegal = 1'b0;
          end else if (funct3 == F3_SR) begin
            w_alu_op  = ALU_SRA;
            w_illegal = 1'b0;
          end
        end else if (funct7 == F7_MULDIV && funct3 == F3_ADD_SUB && ENABLE_MUL != 0) begin
          w_is_mul  = 1'b1;
          w_illegal = 1'b0;
        end
      end
      OP_I: begin
        w_use_imm = 1'b1;
        w_illegal = 1'b0;
        case (funct3)
          F3_ADD_SUB: w_alu_op = ALU_ADD;
          F3_SLL: begin
            w_alu_op  = ALU_SLL;
            w_illegal = (w_imm12[11:5] != 7'd0);
          end
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_SLTU: w_alu_op = ALU_SLTU;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_SR:   w_alu_op = w_imm12[10] ? ALU_SRA : ALU_SRL;
          F3_OR:   w_alu_op = ALU_OR;
          default: w_alu_op = ALU_AND;
        endcase
      end
      default: ;
    endcase
  end

  // ALU datapath; operands are forced to zero unless an instruction is being accepted
  always_comb begin
    w_op_a  = rs1_data & {XLEN{w_accept}};
    w_op_b  = (w_use_imm ? imm : rs2_data) & {XLEN{w_accept}};
    w_shamt = w_op_b[ShW-1:0];
    case (w_alu_op)
      ALU_ADD:  w_alu_result = w_op_a + w_op_b;
      ALU_SUB:  w_alu_result = w_op_a - w_op_b;
      ALU_SLL:  w_alu_result = w_op_a << w_shamt;
      ALU_SLT:  w_alu_result = XLEN'($signed(w_op_a) < $signed(w_op_b));
      ALU_SLTU: w_alu_result = XLEN'(w_op_a < w_op_b);
      ALU_XOR:  w_alu_result = w_op_a ^ w_op_b;
      ALU_SRL:  w_alu_result = w_op_a >> w_shamt;
      ALU_SRA:  w_alu_result = $signed(w_op_a) >>> w_shamt;
      ALU_OR:   w_alu_result = w_op_a | w_op_b;
      default:  w_alu_result = w_op_a & w_op_b;
    endcase
    if (w_illegal) begin
      w_alu_result = '0;
    end
    w_mul_start = w_accept & w_is_mul;
  end

  seq_multiplier #(
    .XLEN     (XLEN),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .step    (enable),
    .clear   (flush),
    .a       (w_op_a),
    .b       (w_op_b),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  // Control state and output buffer; flush wins over any load or transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_rd      <= '0;
      r_out_illegal <= 1'b0;
      r_mul_rd      <= '0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      if (w_mul_start) begin
        r_state  <= MUL;
        r_mul_rd <= rd;
      end else if (r_state == MUL && w_mul_done) begin
        r_state <= IDLE;
      end

      if (w_accept && !w_is_mul) begin
        r_out_valid   <= 1'b1;
        r_out_result  <= w_alu_result;
        r_out_rd      <= rd;
        r_out_illegal <= w_illegal;
      end else if (r_state == MUL && w_mul_done) begin
        r_out_valid   <= 1'b1;
        r_out_result  <= w_mul_product;
        r_out_rd      <= r_mul_rd;
        r_out_illegal <= 1'b0;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Registered outputs
  always_comb begin
    out_valid   = r_out_valid;
    out_result  = r_out_result;
    out_rd      = r_out_rd;
    out_illegal = r_out_illegal;
    busy        = (r_state == MUL);
  end

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed self-checking bench for exec_unit_pipe with default parameters.
module tb_exec_unit_pipe;

  logic        clk = 1'b0;
  logic        rst, enable, flush, in_valid, in_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, out_rd;
  logic [31:0] rs1_data, rs2_data, imm, out_result;
  logic        out_valid, out_ready, out_illegal, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] F0 = 7'b0000000;
  localparam logic [6:0] FA = 7'b0100000;
  localparam logic [6:0] FM = 7'b0000001;

  exec_unit_pipe #(
    .XLEN       (32),
    .ENABLE_MUL (1),
    .MUL_BITS   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rd          (rd),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_illegal (out_illegal),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] iv,
                       input logic [4:0] rdv);
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    rs1_data = a;
    rs2_data = b;
    imm      = iv;
    rd       = rdv;
    in_valid = 1'b1;
  endtask

  // Issue one ALU op, step one edge, check the buffered result; in_valid stays high
  task automatic alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] iv, input logic [31:0] exp, input logic exp_ill);
    drive(op, f3, f7, a, b, iv, 5'd1);
    tick();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, out_result, exp);
    check({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
  endtask

  initial begin
    logic seen;
    rst = 1'b1; enable = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0; rd = '0;
    rs1_data = '0; rs2_data = '0; imm = '0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", {27'd0, out_rd}, 32'd0);
    check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // First ADD, latency one
    drive(R, 3'd0, F0, 32'd5, 32'd7, 32'd0, 5'd3);
    tick();
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", out_result, 32'd12);
    check("add_rd", {27'd0, out_rd}, 32'd3);

    // Back-to-back ALU stream
    alu("sub", R, 3'd0, FA, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 1'b0);
    alu("sra", R, 3'd5, FA, 32'h8000_0000, 32'h21, 32'h0, 32'hC000_0000, 1'b0);
    alu("slt", R, 3'd2, F0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 1'b0);
    alu("sltu", R, 3'd3, F0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0);
    alu("sll", R, 3'd1, F0, 32'h1, 32'h24, 32'h0, 32'h10, 1'b0);
    alu("and", R, 3'd7, F0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0, 32'h0F00_0F00, 1'b0);
    alu("add_wrap", R, 3'd0, F0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h1, 1'b0);
    alu("xori", I, 3'd4, F0, 32'h0000_F0F0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_0F0F, 1'b0);
    alu("srai", I, 3'd5, F0, 32'h8000_0000, 32'h0, 32'h404, 32'hF800_0000, 1'b0);
    alu("srli", I, 3'd5, F0, 32'h8000_0000, 32'h0, 32'h004, 32'h0800_0000, 1'b0);
    alu("sltiu", I, 3'd3, F0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
    alu("slli_bad", I, 3'd1, F0, 32'h1, 32'h0, 32'h021, 32'h0, 1'b1);
    alu("r_alt_xor", R, 3'd4, FA, 32'h3, 32'h5, 32'h0, 32'h0, 1'b1);
    alu("bad_op", 7'b1111111, 3'd0, F0, 32'h3, 32'h5, 32'h0, 32'h0, 1'b1);
    in_valid = 1'b0;
    tick();

    // MUL, enable held high
    drive(R, 3'd0, FM, 32'h0001_0001, 32'h0001_0001, 32'h0, 5'd9);
    tick();
    in_valid = 1'b0;
    check("mul_busy_e0", {31'd0, busy}, 32'd1);
    check("mul_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      check("mul_busy_wait", {30'd0, busy, out_valid}, 32'd2);
    end
    tick();
    check("mul_valid", {31'd0, out_valid}, 32'd1);
    check("mul_result", out_result, 32'h0002_0001);
    check("mul_rd", {27'd0, out_rd}, 32'd9);
    check("mul_busy_done", {31'd0, busy}, 32'd0);

    // MUL with enable low for 5 cycles
    drive(R, 3'd0, FM, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd10);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 36; i++) begin
      enable = !(i >= 11 && i <= 15);
      tick();
    end
    check("mul_en_not_early", {30'd0, busy, out_valid}, 32'd2);
    enable = 1'b1;
    tick();
    check("mul_en_valid", {31'd0, out_valid}, 32'd1);
    check("mul_en_result", out_result, 32'h0000_0001);
    tick();

    // Output stall with a pending ADD
    out_ready = 1'b0;
    drive(R, 3'd0, F0, 32'd100, 32'd23, 32'd0, 5'd4);
    tick();
    check("stall_first", out_result, 32'd123);
    drive(R, 3'd0, F0, 32'd1, 32'd2, 32'd0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_hold", out_result, 32'd123);
      check("stall_rd_hold", {27'd0, out_rd}, 32'd4);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("stall_next_result", out_result, 32'd3);
    check("stall_next_rd", {27'd0, out_rd}, 32'd5);
    tick();

    // Flush at MUL cycle 10
    drive(R, 3'd0, FM, 32'd7, 32'd6, 32'd0, 5'd2);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", {31'd0, seen}, 32'd0);

    // MUL after flush starts from a clean accumulator
    drive(R, 3'd0, FM, 32'd3, 32'd5, 32'd0, 5'd6);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("post_flush_mul_valid", {31'd0, out_valid}, 32'd1);
    check("post_flush_mul_result", out_result, 32'd15);
    tick();

    // Reset mid-MUL abandons the operation
    drive(R, 3'd0, FM, 32'd9, 32'd9, 32'd0, 5'd7);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("rst_mid_no_result", {31'd0, seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
